rvn_seq_exec_core: RTL and testbench

//  Parametrised successor of the 16-bit single-issue datapath. Integrates decode, register file,

---
 rtl/rvn_seq_exec_core.sv | 214 +++++++++++++++++++++
 tb/tb_rvn_seq_exec_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvn_seq_exec_core.sv
`default_nettype none
// ============================================================================
// Module   : rvn_seq_exec_core
// Purpose  : Sequenced execution core. Accepts {opcode, rd, rs1, rs2} over a
//            valid/ready handshake, reads the x0-is-zero register file,
//            executes the operation (single-cycle ALU or iterative restoring
//            divider) and writes the result back to the register file.
// Ports    : rv16_cpu_clock / rv16_cpu_reset  - clock, sync active-high reset
//            instr_in, instr_valid, instr_ready - instruction handshake
//            wb_valid, wb_addr, wb_data        - write-back report (1 cycle)
//            busy                              - FSM not idle
//            illegal_op                        - sticky unsupported-opcode flag
//            dbg_addr, dbg_data                - combinational debug read
// Config   : RVN_DIV_UNIT_EN enables the divider (DIV/REM); without it
//            opcodes 3 and 7 are treated as illegal.
// Revision : 1.0 - initial release
// ============================================================================
module rvn_seq_exec_core #(
  parameter int  DATA   = 16,
  parameter int  NREG   = 16,
  parameter int  OPCODE = 4,
  localparam int RADDR  = $clog2(NREG),
  localparam int INSTR  = OPCODE + 3 * RADDR
) (
  input  logic             rv16_cpu_clock,
  input  logic             rv16_cpu_reset,
  input  logic [INSTR-1:0] instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             wb_valid,
  output logic [RADDR-1:0] wb_addr,
  output logic [DATA-1:0]  wb_data,
  output logic             busy,
  output logic             illegal_op,
  input  logic [RADDR-1:0] dbg_addr,
  output logic [DATA-1:0]  dbg_data
);

  localparam logic [OPCODE-1:0] OP_ADD = OPCODE'(0);
  localparam logic [OPCODE-1:0] OP_SUB = OPCODE'(1);
  localparam logic [OPCODE-1:0] OP_MUL = OPCODE'(2);
  localparam logic [OPCODE-1:0] OP_XOR = OPCODE'(4);
  localparam logic [OPCODE-1:0] OP_AND = OPCODE'(5);
  localparam logic [OPCODE-1:0] OP_OR  = OPCODE'(6);
  localparam logic [OPCODE-1:0] OP_NOP = OPCODE'(8);

`ifdef RVN_DIV_UNIT_EN
  localparam logic [OPCODE-1:0] OP_DIV = OPCODE'(3);
  localparam logic [OPCODE-1:0] OP_REM = OPCODE'(7);
  localparam int                CNTW   = $clog2(DATA);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DIV = 2'd1, ST_WB = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WB = 2'd2} state_t;
`endif

  state_t state, state_next;

  logic [NREG-1:0][DATA-1:0] regs;

  logic [OPCODE-1:0] op_f, op_q;
  logic [RADDR-1:0]  rd_f, rs1_f, rs2_f, rd_q;
  logic [DATA-1:0]   rs1_val, rs2_val, a_q, b_q, result;
  logic              accept, op_single, op_nop, op_legal;

  assign {op_f, rd_f, rs1_f, rs2_f} = instr_in;

  // x0 is hard-wired to zero on every read path
  assign rs1_val  = (rs1_f == '0)    ? '0 : regs[rs1_f];
  assign rs2_val  = (rs2_f == '0)    ? '0 : regs[rs2_f];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  assign accept = instr_valid && instr_ready;

`ifdef RVN_DIV_UNIT_EN
  logic              op_div, div_last;
  logic [DATA-1:0]   quo_q, rem_q, quo_n, rem_n;
  logic [DATA:0]     div_tmp, div_diff;
  logic              div_ge;
  logic [CNTW-1:0]   cnt_q;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. The remainder stays below the
  // divisor, so the difference always fits in DATA bits.
  assign div_tmp  = {rem_q, quo_q[DATA-1]};
  assign div_diff = div_tmp - {1'b0, b_q};
  assign div_ge   = (div_tmp >= {1'b0, b_q});
  assign rem_n    = div_ge ? div_diff[DATA-1:0] : div_tmp[DATA-1:0];
  assign quo_n    = {quo_q[DATA-2:0], div_ge};
  assign div_last = (cnt_q == CNTW'(DATA - 1));

  always_ff @(posedge rv16_cpu_clock) begin
    if (rv16_cpu_reset) begin
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      quo_q <= rs1_val;
      rem_q <= '0;
      cnt_q <= '0;
    end else if (state == ST_DIV) begin
      if (b_q == '0) begin
        quo_q <= '1;
        rem_q <= a_q;
      end else begin
        quo_q <= quo_n;
        rem_q <= rem_n;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
`endif

  // Opcode decode
  always_comb begin
    op_single = 1'b0;
    op_nop    = 1'b0;
`ifdef RVN_DIV_UNIT_EN
    op_div    = 1'b0;
`endif
    case (op_f)
      OP_ADD, OP_SUB, OP_MUL, OP_XOR, OP_AND, OP_OR: op_single = 1'b1;
      OP_NOP:                                       op_nop    = 1'b1;
`ifdef RVN_DIV_UNIT_EN
      OP_DIV, OP_REM:                               op_div    = 1'b1;
`endif
      default: ;
    endcase
`ifdef RVN_DIV_UNIT_EN
    op_legal = op_single | op_nop | op_div;
`else
    op_legal = op_single | op_nop;
`endif
  end

  // Result of the latched instruction; product keeps the low DATA bits
  always_comb begin
    result = '0;
    case (op_q)
      OP_ADD: result = a_q + b_q;
      OP_SUB: result = a_q - b_q;
      OP_MUL: result = a_q * b_q;
      OP_XOR: result = a_q ^ b_q;
      OP_AND: result = a_q & b_q;
      OP_OR:  result = a_q | b_q;
`ifdef RVN_DIV_UNIT_EN
      OP_DIV: result = quo_q;
      OP_REM: result = rem_q;
`endif
      default: result = '0;
    endcase
  end

  always_ff @(posedge rv16_cpu_clock) begin
    if (rv16_cpu_reset) state <= ST_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next  = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    wb_valid    = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) begin
          if (op_single) state_next = ST_WB;
`ifdef RVN_DIV_UNIT_EN
          else if (op_div) state_next = ST_DIV;
`endif
        end
      end
`ifdef RVN_DIV_UNIT_EN
      ST_DIV: begin
        // Divide by zero skips the iteration entirely
        if ((b_q == '0) || div_last) state_next = ST_WB;
      end
`endif
      ST_WB: begin
        wb_valid   = 1'b1;
        wb_addr    = rd_q;
        wb_data    = result;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge rv16_cpu_clock) begin
    if (rv16_cpu_reset) begin
      regs       <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      illegal_op <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= op_f;
        rd_q <= rd_f;
        a_q  <= rs1_val;
        b_q  <= rs2_val;
        if (!op_legal) illegal_op <= 1'b1;
      end
      if ((state == ST_WB) && (rd_q != '0)) regs[rd_q] <= result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rvn_seq_exec_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvn_seq_exec_core
// Purpose  : Directed self-checking bench for rvn_seq_exec_core (DATA=16,
//            NREG=16). Follows RVN_DIV_UNIT_EN to pick divider or
//            illegal-opcode expectations for opcodes 3 and 7.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvn_seq_exec_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr_in = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready, wb_valid, busy, illegal_op;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data, dbg_data;
  logic [3:0]  dbg_addr = '0;

  int total = 0;
  int bad   = 0;

  rvn_seq_exec_core #(.DATA(16), .NREG(16), .OPCODE(4)) dut (
    .rv16_cpu_clock (clk),
    .rv16_cpu_reset (rst),
    .instr_in       (instr_in),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .busy           (busy),
    .illegal_op     (illegal_op),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data)
  );

  always #5 clk = ~clk;

  // Issue one instruction and wait up to maxc cycles for its write-back.
  // lat = cycles from accept edge to wb_valid (-1 when no write-back occurs).
  // hs_ok clears if busy/instr_ready misbehave while the op is in flight.
  task automatic issue(input logic [3:0] op, rd, rs1, rs2, input int maxc,
                       output int lat, output logic [15:0] d, output logic [3:0] a,
                       output logic [15:0] dbg_pre, output bit hs_ok);
    int n;
    @(negedge clk);
    instr_in    = {op, rd, rs1, rs2};
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = -1; d = '0; a = '0; dbg_pre = '0; hs_ok = 1'b1;
    for (int c = 1; c <= maxc; c++) begin
      if (busy !== 1'b1 || instr_ready !== 1'b0) hs_ok = 1'b0;
      if (wb_valid === 1'b1) begin
        lat = c; d = wb_data; a = wb_addr; dbg_pre = dbg_data;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic check_regs_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      total++;
      if (dbg_data !== 16'h0) begin
        bad++;
        $display("FAIL %s r%0d: got %h want 0000", tag, i, dbg_data);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset ready: got %b want 1", instr_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset illegal: got %b want 0", illegal_op); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset wb_valid: got %b want 0", wb_valid); end
    total++; if (wb_addr !== 4'h0 || wb_data !== 16'h0) begin
      bad++; $display("FAIL reset wb_addr/data: got %h/%h want 0/0000", wb_addr, wb_data);
    end
    check_regs_zero("reset_regs");
  endtask

  // Seed operand registers (all registers are zero after reset, so no
  // instruction sequence could otherwise create non-zero values).
  task automatic preload();
    logic [15:0][15:0] pre;
    pre    = '0;
    pre[1] = 16'h0007;
    pre[2] = 16'hFFFE;
    pre[8] = 16'h0064;
    pre[9] = 16'h0007;
    pre[10] = 16'h0005;
    @(negedge clk);
    force dut.regs = pre;
    @(posedge clk);
    #1 release dut.regs;
    dbg_addr = 4'd1; #1;
    total++; if (dbg_data !== 16'h0007) begin bad++; $display("FAIL preload r1: got %h want 0007", dbg_data); end
    dbg_addr = 4'd2; #1;
    total++; if (dbg_data !== 16'hFFFE) begin bad++; $display("FAIL preload r2: got %h want FFFE", dbg_data); end
  endtask

  task automatic test_alu();
    logic [3:0]  v_op  [7] = '{4'h0, 4'h2, 4'h1, 4'h4, 4'h5, 4'h6, 4'h1};
    logic [3:0]  v_rd  [7] = '{4'd3, 4'd4, 4'd1, 4'd5, 4'd6, 4'd7, 4'd15};
    logic [3:0]  v_rs1 [7] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd8, 4'd8, 4'd9};
    logic [3:0]  v_rs2 [7] = '{4'd2, 4'd2, 4'd1, 4'd2, 4'd9, 4'd9, 4'd8};
    logic [15:0] v_exp [7] = '{16'h0005, 16'h0004, 16'hFFF9, 16'h0007, 16'h0004, 16'h0067, 16'hFFA3};
    int lat; logic [15:0] d, dp; logic [3:0] a; bit hs;
    for (int i = 0; i < 7; i++) begin
      dbg_addr = v_rd[i];
      issue(v_op[i], v_rd[i], v_rs1[i], v_rs2[i], 5, lat, d, a, dp, hs);
      total++; if (lat !== 1) begin bad++; $display("FAIL alu%0d latency: got %0d want 1", i, lat); end
      total++; if (d !== v_exp[i]) begin bad++; $display("FAIL alu%0d wb_data: got %h want %h", i, d, v_exp[i]); end
      total++; if (a !== v_rd[i]) begin bad++; $display("FAIL alu%0d wb_addr: got %h want %h", i, a, v_rd[i]); end
      total++; if (!hs) begin bad++; $display("FAIL alu%0d handshake: busy/ready got %b/%b want 1/0", i, busy, instr_ready); end
      @(posedge clk); #1;
      total++; if (dbg_data !== v_exp[i]) begin bad++; $display("FAIL alu%0d regfile: got %h want %h", i, dbg_data, v_exp[i]); end
      total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL alu%0d ready after wb: got %b want 1", i, instr_ready); end
    end
  endtask

  task automatic test_x0();
    int lat; logic [15:0] d, dp; logic [3:0] a; bit hs;
    dbg_addr = 4'd0;
    issue(4'h0, 4'd0, 4'd1, 4'd1, 5, lat, d, a, dp, hs);
    total++; if (lat !== 1 || a !== 4'd0 || d !== 16'hFFF2) begin
      bad++; $display("FAIL x0 write report: got lat=%0d addr=%h data=%h want 1/0/FFF2", lat, a, d);
    end
    @(posedge clk); #1;
    total++; if (dbg_data !== 16'h0) begin bad++; $display("FAIL x0 stays zero: got %h want 0000", dbg_data); end
    issue(4'h0, 4'd11, 4'd0, 4'd9, 5, lat, d, a, dp, hs);
    total++; if (d !== 16'h0007) begin bad++; $display("FAIL x0 read: got %h want 0007", d); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] d, dp; logic [3:0] a; bit hs;
    dbg_addr = 4'd12;
    issue(4'h0, 4'd12, 4'd9, 4'd9, 5, lat, d, a, dp, hs);
    total++; if (d !== 16'h000E) begin bad++; $display("FAIL b2b first: got %h want 000E", d); end
    issue(4'h0, 4'd12, 4'd12, 4'd9, 5, lat, d, a, dp, hs);
    total++; if (d !== 16'h0015 || lat !== 1) begin bad++; $display("FAIL b2b dependent: got %h lat=%0d want 0015 lat=1", d, lat); end
    total++; if (dp !== 16'h000E) begin bad++; $display("FAIL dbg pre-write: got %h want 000E", dp); end
    @(posedge clk); #1;
    total++; if (dbg_data !== 16'h0015) begin bad++; $display("FAIL dbg post-write: got %h want 0015", dbg_data); end
  endtask

  task automatic test_nop_illegal();
    int lat; logic [15:0] d, dp; logic [3:0] a; bit hs;
    issue(4'h8, 4'd3, 4'd1, 4'd2, 4, lat, d, a, dp, hs);
    total++; if (lat !== -1) begin bad++; $display("FAIL nop no-wb: got lat=%0d want none", lat); end
    total++; if (busy !== 1'b0 || instr_ready !== 1'b1 || illegal_op !== 1'b0) begin
      bad++; $display("FAIL nop state: busy/ready/illegal got %b/%b/%b want 0/1/0", busy, instr_ready, illegal_op);
    end
    issue(4'hF, 4'd13, 4'd1, 4'd2, 4, lat, d, a, dp, hs);
    total++; if (lat !== -1) begin bad++; $display("FAIL illegal no-wb: got lat=%0d want none", lat); end
    total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL illegal flag: got %b want 1", illegal_op); end
    issue(4'h0, 4'd13, 4'd9, 4'd10, 5, lat, d, a, dp, hs);
    total++; if (lat !== 1 || d !== 16'h000C) begin bad++; $display("FAIL add after illegal: got %h lat=%0d want 000C lat=1", d, lat); end
    total++; if (illegal_op !== 1'b1) begin bad++; $display("FAIL illegal sticky: got %b want 1", illegal_op); end
  endtask

  task automatic test_div();
    int lat; logic [15:0] d, dp; logic [3:0] a; bit hs;
`ifdef RVN_DIV_UNIT_EN
    logic [3:0]  v_op  [4] = '{4'h3, 4'h7, 4'h3, 4'h7};
    logic [3:0]  v_rs2 [4] = '{4'd9, 4'd9, 4'd0, 4'd0};
    logic [3:0]  v_rs1 [4] = '{4'd8, 4'd8, 4'd10, 4'd10};
    logic [15:0] v_exp [4] = '{16'h000E, 16'h0002, 16'hFFFF, 16'h0005};
    int          v_lat [4] = '{17, 17, 2, 2};
    for (int i = 0; i < 4; i++) begin
      issue(v_op[i], 4'd14, v_rs1[i], v_rs2[i], 40, lat, d, a, dp, hs);
      total++; if (lat !== v_lat[i]) begin bad++; $display("FAIL div%0d latency: got %0d want %0d", i, lat, v_lat[i]); end
      total++; if (d !== v_exp[i] || a !== 4'd14) begin bad++; $display("FAIL div%0d result: got %h@%h want %h@e", i, d, a, v_exp[i]); end
      total++; if (!hs) begin bad++; $display("FAIL div%0d busy/ready during op: got busy=%b ready=%b want 1/0", i, busy, instr_ready); end
    end
`else
    logic [3:0] v_op [2] = '{4'h3, 4'h7};
    for (int i = 0; i < 2; i++) begin
      do_reset();
      issue(v_op[i], 4'd14, 4'd8, 4'd9, 20, lat, d, a, dp, hs);
      total++; if (lat !== -1) begin bad++; $display("FAIL nodiv op%0h no-wb: got lat=%0d want none", v_op[i], lat); end
      total++; if (illegal_op !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL nodiv op%0h illegal/busy: got %b/%b want 1/0", v_op[i], illegal_op, busy);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
`ifdef RVN_DIV_UNIT_EN
    instr_in    = {4'h3, 4'd13, 4'd8, 4'd9};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (4) begin
      if (wb_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid-div busy: got %b want 1", busy); end
    @(negedge clk);
    rst = 1'b1;
`else
    instr_in    = {4'h0, 4'd3, 4'd1, 4'd2};
    instr_valid = 1'b1;
    rst         = 1'b1;
`endif
    @(posedge clk);
    #1 instr_valid = 1'b0;
    total++; if (busy !== 1'b0 || instr_ready !== 1'b1) begin
      bad++; $display("FAIL reset abort state: busy/ready got %b/%b want 0/1", busy, instr_ready);
    end
    if (wb_valid !== 1'b0) seen = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (wb_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen) begin bad++; $display("FAIL reset abort wb_valid: got 1 want 0"); end
    check_regs_zero("abort_regs");
  endtask

  initial begin
    test_reset();
    preload();
    test_alu();
    test_x0();
    test_back_to_back();
    test_nop_illegal();
    test_div();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
